// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler that shares one ultrasonic ranging engine among several sensors.
// Each ping is bounded by a timeout and followed by a guard gap against acoustic crosstalk.
module ultrasonic_scan_scheduler #(
    parameter int N_SENSORS   = 4,
    parameter int SEL_W       = $clog2(N_SENSORS),
    parameter int DIST_W      = 16,
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int GAP_CYC     = 6_000_000
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_enable,
    input  logic [N_SENSORS-1:0]          i_sensor_mask,
    output logic                          o_eng_start,
    output logic [SEL_W-1:0]              o_eng_sel,
    input  logic                          i_eng_done,
    input  logic [DIST_W-1:0]             i_eng_distance,
    output logic [N_SENSORS*DIST_W-1:0]   o_dist_table,
    output logic [N_SENSORS-1:0]          o_dist_valid,
    output logic [N_SENSORS-1:0]          o_timeout_flag,
    output logic                          o_busy,
    output logic                          o_frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT_DONE,
        S_STORE,
        S_GAP
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYC - 1);

    state_t              r_state;
    state_t              w_next;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_last;
    logic [SEL_W-1:0]    w_pick;
    logic                w_pick_above;
    logic                w_mask_above_sel;
    logic [31:0]         r_timer;
    logic [DIST_W-1:0]   r_result;
    logic                r_good;
    logic [DIST_W-1:0]   r_table [N_SENSORS];
    logic [N_SENSORS-1:0] r_valid;
    logic [N_SENSORS-1:0] r_tflag;

    // Next sensor: lowest set mask bit above the last served index, else wrap to the lowest set bit.
    always_comb begin
        w_pick       = '0;
        w_pick_above = 1'b0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (i_sensor_mask[i] && (i > int'(r_last))) begin
                w_pick       = SEL_W'(i);
                w_pick_above = 1'b1;
            end
        end
        if (!w_pick_above) begin
            for (int i = N_SENSORS - 1; i >= 0; i--) begin
                if (i_sensor_mask[i]) begin
                    w_pick = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_mask_above_sel = 1'b0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (i_sensor_mask[i] && (i > int'(r_sel))) begin
                w_mask_above_sel = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_eng_start  = 1'b0;
        o_busy       = 1'b1;
        o_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_enable && (i_sensor_mask != '0)) begin
                    w_next = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!i_enable || (i_sensor_mask == '0)) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_START;
                end
            end
            S_START: begin
                o_eng_start = 1'b1;
                w_next      = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A done pulse on the final timer cycle still counts as a good result.
                if (i_eng_done || (r_timer == TIMEOUT_LAST)) begin
                    w_next = S_STORE;
                end
            end
            S_STORE: begin
                o_frame_done = !w_mask_above_sel;
                w_next       = S_GAP;
            end
            S_GAP: begin
                if (r_timer == GAP_LAST) begin
                    w_next = i_enable ? S_SELECT : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sel    <= '0;
            r_last   <= SEL_W'(N_SENSORS - 1);
            r_timer  <= '0;
            r_result <= '0;
            r_good   <= 1'b0;
            r_valid  <= '0;
            r_tflag  <= '0;
            for (int i = 0; i < N_SENSORS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            case (r_state)
                S_SELECT: begin
                    if (w_next == S_START) begin
                        r_sel  <= w_pick;
                        r_last <= w_pick;
                    end
                end
                S_START: begin
                    r_timer <= '0;
                    r_good  <= 1'b0;
                end
                S_WAIT_DONE: begin
                    r_timer <= r_timer + 32'd1;
                    if (i_eng_done) begin
                        r_result <= i_eng_distance;
                        r_good   <= 1'b1;
                    end
                end
                S_STORE: begin
                    r_timer <= '0;
                    if (r_good) begin
                        r_table[r_sel] <= r_result;
                        r_valid[r_sel] <= 1'b1;
                        r_tflag[r_sel] <= 1'b0;
                    end else begin
                        r_valid[r_sel] <= 1'b0;
                        r_tflag[r_sel] <= 1'b1;
                    end
                end
                S_GAP: begin
                    r_timer <= r_timer + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_dist_table = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            o_dist_table[i*DIST_W +: DIST_W] = r_table[i];
        end
    end

    assign o_eng_sel      = r_sel;
    assign o_dist_valid   = r_valid;
    assign o_timeout_flag = r_tflag;

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Bench for ultrasonic_scan_scheduler: directed scenarios plus randomized pings
// checked against a per-ping round-robin/table model.
module tb_ultrasonic_scan_scheduler;

    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int DW  = 16;
    localparam int TO  = 100;
    localparam int GAP = 20;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [N-1:0]      mask;
    logic              eng_done;
    logic [DW-1:0]     eng_distance;
    logic              eng_start;
    logic [SW-1:0]     eng_sel;
    logic [N*DW-1:0]   dist_table;
    logic [N-1:0]      dist_valid;
    logic [N-1:0]      timeout_flag;
    logic              busy;
    logic              frame_done;

    ultrasonic_scan_scheduler #(
        .N_SENSORS(N), .SEL_W(SW), .DIST_W(DW), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_sensor_mask(mask),
        .o_eng_start(eng_start), .o_eng_sel(eng_sel), .i_eng_done(eng_done),
        .i_eng_distance(eng_distance), .o_dist_table(dist_table), .o_dist_valid(dist_valid),
        .o_timeout_flag(timeout_flag), .o_busy(busy), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int cycle       = 0;
    int frameCount  = 0;
    int startCount  = 0;

    logic [DW-1:0] mTable [N];
    logic [N-1:0]  mValid;
    logic [N-1:0]  mTflag;
    int            mLast;
    int            expFrames;
    int            prevStart;
    bit            prevValid;
    int            expSpacing;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic finishTest();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        if (frame_done) frameCount++;
        if (eng_start) startCount++;
    endtask

    function automatic int nextSel(input int last, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit anyAbove(input int s, input logic [N-1:0] m);
        for (int i = s + 1; i < N; i++) begin
            if (m[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [63:0] packTable();
        return {mTable[3], mTable[2], mTable[1], mTable[0]};
    endfunction

    task automatic resetModel();
        for (int i = 0; i < N; i++) mTable[i] = '0;
        mValid    = '0;
        mTflag    = '0;
        mLast     = N - 1;
        prevValid = 1'b0;
    endtask

    task automatic checkModel();
        checkOutput("distTable", 64'(dist_table), packTable());
        checkOutput("distValid", 64'(dist_valid), 64'(mValid));
        checkOutput("timeoutFlag", 64'(timeout_flag), 64'(mTflag));
        checkOutput("frameCount", 64'(frameCount), 64'(expFrames));
    endtask

    task automatic waitStart();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (eng_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkOutput("engStartSeen", 64'd0, 64'd1);
            finishTest();
        end
    endtask

    // One measurement: delay = wait-cycle index of the done pulse; answer=0 leaves the engine silent.
    task automatic applyStimulus(input int delay, input bit answer, input logic [DW-1:0] d,
                                 input logic [N-1:0] newMask, input bit spurious, input bit dropEnable);
        int s;
        s = nextSel(mLast, mask);
        waitStart();
        checkOutput("engSel", 64'(eng_sel), 64'(s));
        if (prevValid) checkOutput("pingSpacing", 64'(cycle - prevStart), 64'(expSpacing));
        checkModel();
        prevStart = cycle;
        prevValid = 1'b1;
        mLast     = s;
        mask      = newMask;
        if (dropEnable) enable = 1'b0;
        step();
        if (answer) begin
            repeat (delay) step();
            eng_done     = 1'b1;
            eng_distance = d;
            step();
            eng_done     = 1'b0;
            expSpacing   = delay + GAP + 4;
            mTable[s]    = d;
            mValid[s]    = 1'b1;
            mTflag[s]    = 1'b0;
            if (spurious) begin
                step();
                eng_done     = 1'b1;
                eng_distance = 16'hBEEF;
                step();
                eng_done     = 1'b0;
            end
        end else begin
            expSpacing = TO + GAP + 3;
            mValid[s]  = 1'b0;
            mTflag[s]  = 1'b1;
        end
        if (!anyAbove(s, newMask)) expFrames++;
    endtask

    initial begin
        int s;
        int d;
        int startsBefore;
        logic [N-1:0] nm;

        reset_n      = 1'b0;
        enable       = 1'b0;
        mask         = 4'b1111;
        eng_done     = 1'b0;
        eng_distance = '0;
        expFrames    = 0;
        expSpacing   = 0;
        prevStart    = 0;
        resetModel();
        repeat (3) step();
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstStart", 64'(eng_start), 64'd0);
        checkOutput("rstSel", 64'(eng_sel), 64'd0);
        checkOutput("rstFrame", 64'(frame_done), 64'd0);
        checkModel();
        reset_n = 1'b1;
        step();
        enable = 1'b1;

        // Full mask, fixed 30-cycle echo; fifth start also checks the finished table.
        for (int k = 0; k < 5; k++) begin
            s = nextSel(mLast, mask);
            applyStimulus(30, 1'b1, DW'(100 + 10 * s), (k == 4) ? 4'b0101 : 4'b1111, 1'b0, 1'b0);
        end

        // Alternating 0/2 with sparse mask.
        for (int k = 0; k < 4; k++) begin
            s = nextSel(mLast, mask);
            applyStimulus(12, 1'b1, DW'(200 + s), (k == 3) ? 4'b1111 : 4'b0101, 1'b0, 1'b0);
        end

        // Sensor 1 silent; others answer on the last legal cycle, with a spurious done in the gap.
        for (int k = 0; k < 5; k++) begin
            s = nextSel(mLast, mask);
            applyStimulus(TO - 1, (s != 1), DW'(300 + s), 4'b1111, 1'b1, 1'b0);
        end

        // Enable drops mid-measurement: store, full gap, then idle with no further pings.
        applyStimulus(10, 1'b1, 16'd77, 4'b1111, 1'b0, 1'b1);
        while (cycle < prevStart + 22 + 10) step();
        checkOutput("busyInGap", 64'(busy), 64'd1);
        step();
        checkOutput("busyAfterGap", 64'(busy), 64'd0);
        startsBefore = startCount;
        repeat (60) step();
        checkOutput("noStartWhenOff", 64'(startCount), 64'(startsBefore));
        checkOutput("busyIdle", 64'(busy), 64'd0);
        enable    = 1'b1;
        prevValid = 1'b0;

        // Randomized pings with random mask changes, delays and timeouts.
        for (int k = 0; k < 30; k++) begin
            d  = int'($urandom_range(0, 130));
            nm = N'($urandom_range(1, 15));
            applyStimulus(d, (d < TO), DW'($urandom_range(2, 400)), nm, (d < TO) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        // Asynchronous reset in the middle of a wait.
        s = nextSel(mLast, mask);
        waitStart();
        checkOutput("preRstSel", 64'(eng_sel), 64'(s));
        repeat (5) step();
        #2;
        reset_n = 1'b0;
        mask    = 4'b0110;
        #1;
        resetModel();
        checkOutput("asyncRstBusy", 64'(busy), 64'd0);
        checkOutput("asyncRstSel", 64'(eng_sel), 64'd0);
        checkOutput("asyncRstTable", 64'(dist_table), 64'd0);
        checkOutput("asyncRstValid", 64'(dist_valid), 64'd0);
        checkOutput("asyncRstTflag", 64'(timeout_flag), 64'd0);
        repeat (2) step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s = nextSel(mLast, mask);
            applyStimulus(5 + k, 1'b1, DW'(50 + s), 4'b0110, 1'b0, 1'b0);
        end
        waitStart();
        checkModel();
        finishTest();
    end

endmodule
